mem_port_arbiter: RTL and testbench

Shares one single-ported unified memory between the datapath's instruction-fetch port (i_*) and data port (d_*). It latches one request at a time, drives the memory with a req/ack handshake, and returns completion and read data to the requesting side. It also reports per-side wait status so the hazard logic can stall the pipeline, and it keeps wrapping grant counters for debug.

---
 rtl/mem_port_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported memory between the instruction-fetch
//            port (i_*) and the data port (d_*). One access is in flight at
//            a time. Ties are broken against the side granted last, and
//            per-side wrapping grant counters are kept for debug.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  // instruction-fetch side
  input  logic                 i_readM,
  input  logic [WORD_SIZE-1:0] i_address,
  output logic [WORD_SIZE-1:0] i_rdata,
  output logic                 i_done,
  output logic                 i_wait,
  // data side
  input  logic                 d_readM,
  input  logic                 d_writeM,
  input  logic [WORD_SIZE-1:0] d_address,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 d_done,
  output logic                 d_wait,
  // memory side
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata,
  input  logic                 mem_ack,
  // debug
  output logic [WORD_SIZE-1:0] grant_cnt_i,
  output logic [WORD_SIZE-1:0] grant_cnt_d
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_last_grant_d;  // 1: most recent grant went to D
  logic [WORD_SIZE-1:0] r_i_hold;
  logic [WORD_SIZE-1:0] r_d_hold;

  logic w_i_pend;
  logic w_d_pend;
  logic w_ack_i;
  logic w_ack_d;
  logic w_idle_grant_i;
  logic w_idle_grant_d;
  logic w_grant_i;
  logic w_grant_d;

  // a write on the data side takes precedence over a simultaneous read
  assign w_i_pend = i_readM;
  assign w_d_pend = d_readM | d_writeM;

  // an ack only counts while an access is actually outstanding
  assign w_ack_i = (r_state == BUSY_I) && mem_ack;
  assign w_ack_d = (r_state == BUSY_D) && mem_ack;

  // from IDLE a tie goes to the side that was not granted last
  assign w_idle_grant_d = (r_state == IDLE) && w_d_pend && (!w_i_pend || !r_last_grant_d);
  assign w_idle_grant_i = (r_state == IDLE) && w_i_pend && !w_idle_grant_d;

  // at an ack edge only the opposite side may be granted (direct handoff)
  assign w_grant_d = w_idle_grant_d || (w_ack_i && w_d_pend);
  assign w_grant_i = w_idle_grant_i || (w_ack_d && w_i_pend);

  assign i_done  = w_ack_i;
  assign d_done  = w_ack_d;
  assign i_rdata = w_ack_i ? mem_rdata : r_i_hold;
  // store completions leave the load-data path untouched
  assign d_rdata = (w_ack_d && !mem_we) ? mem_rdata : r_d_hold;
  assign i_wait  = i_readM && !w_ack_i;
  assign d_wait  = w_d_pend && !w_ack_d;

  // arbitration FSM: owns the memory request registers and grant counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= IDLE;
      r_last_grant_d <= 1'b0;
      mem_req        <= 1'b0;
      mem_we         <= 1'b0;
      mem_addr       <= '0;
      mem_wdata      <= '0;
      grant_cnt_i    <= '0;
      grant_cnt_d    <= '0;
    end else if (w_grant_d) begin
      r_state        <= BUSY_D;
      r_last_grant_d <= 1'b1;
      mem_req        <= 1'b1;
      mem_we         <= d_writeM;
      mem_addr       <= d_address;
      mem_wdata      <= d_wdata;
      grant_cnt_d    <= grant_cnt_d + WORD_SIZE'(1);
    end else if (w_grant_i) begin
      r_state        <= BUSY_I;
      r_last_grant_d <= 1'b0;
      mem_req        <= 1'b1;
      mem_we         <= 1'b0;
      mem_addr       <= i_address;
      mem_wdata      <= '0;
      grant_cnt_i    <= grant_cnt_i + WORD_SIZE'(1);
    end else if (w_ack_i || w_ack_d) begin
      r_state        <= IDLE;
      mem_req        <= 1'b0;
    end
  end

  // read-data hold registers capture memory data on a read completion
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_i_hold <= '0;
      r_d_hold <= '0;
    end else begin
      if (w_ack_i) begin
        r_i_hold <= mem_rdata;
      end
      if (w_ack_d && !mem_we) begin
        r_d_hold <= mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter: directed scenarios
//            plus a randomized two-requester run against a memory-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  logic        clk;
  logic        reset_n;
  logic        i_readM;
  logic [15:0] i_address;
  logic [15:0] i_rdata;
  logic        i_done;
  logic        i_wait;
  logic        d_readM;
  logic        d_writeM;
  logic [15:0] d_address;
  logic [15:0] d_wdata;
  logic [15:0] d_rdata;
  logic        d_done;
  logic        d_wait;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] grant_cnt_i;
  logic [15:0] grant_cnt_d;

  int n_checks = 0;
  int n_errors = 0;

  // randomized-run state shared by the forked threads
  logic [15:0] ref_mem [256];
  logic [15:0] sim_mem [256];
  int          r_ni;
  int          r_nd;
  localparam int N_RAND = 30;

  mem_port_arbiter #(.WORD_SIZE(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_readM(i_readM), .i_address(i_address), .i_rdata(i_rdata),
    .i_done(i_done), .i_wait(i_wait),
    .d_readM(d_readM), .d_writeM(d_writeM), .d_address(d_address),
    .d_wdata(d_wdata), .d_rdata(d_rdata), .d_done(d_done), .d_wait(d_wait),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .grant_cnt_i(grant_cnt_i), .grant_cnt_d(grant_cnt_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    i_readM = 0; i_address = 0; d_readM = 0; d_writeM = 0;
    d_address = 0; d_wdata = 0; mem_ack = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset_n = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset_n = 1;
    #2 reset_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b0) begin n_errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_checks++; if (mem_we !== 1'b0) begin n_errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_checks++; if (mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin n_errors++; $display("FAIL reset_mem_bus: got addr %h wdata %h want 0 0", mem_addr, mem_wdata); end
    n_checks++; if (i_rdata !== 16'h0 || d_rdata !== 16'h0) begin n_errors++; $display("FAIL reset_rdata: got i %h d %h want 0 0", i_rdata, d_rdata); end
    n_checks++; if (grant_cnt_i !== 16'h0 || grant_cnt_d !== 16'h0) begin n_errors++; $display("FAIL reset_counters: got i %0d d %0d want 0 0", grant_cnt_i, grant_cnt_d); end
    n_checks++; if ({i_done, d_done, i_wait, d_wait} !== 4'b0) begin n_errors++; $display("FAIL reset_handshake: got %b want 0000", {i_done, d_done, i_wait, d_wait}); end
    @(posedge clk);
    #1 reset_n = 1;
  endtask

  task automatic test_single_fetch();
    bit ok;
    @(posedge clk); #1;
    i_readM = 1; i_address = 16'h0010;
    ok = 0;
    for (int n = 0; n < 8; n++) begin @(negedge clk); if (mem_req === 1'b1) begin ok = 1; break; end end
    n_checks++; if (!ok) begin n_errors++; $display("FAIL fetch_grant_timeout: got no mem_req want mem_req"); end
    n_checks++; if (mem_addr !== 16'h0010 || mem_we !== 1'b0) begin n_errors++; $display("FAIL fetch_bus: got addr %h we %b want 0010 0", mem_addr, mem_we); end
    n_checks++; if (i_wait !== 1'b1) begin n_errors++; $display("FAIL fetch_wait: got %b want 1", i_wait); end
    @(posedge clk); #1;
    @(negedge clk);
    n_checks++; if (i_done !== 1'b0) begin n_errors++; $display("FAIL fetch_early_done: got %b want 0", i_done); end
    @(posedge clk); #1;
    mem_ack = 1; mem_rdata = 16'hABCD;
    @(negedge clk);
    n_checks++; if (i_done !== 1'b1 || i_rdata !== 16'hABCD) begin n_errors++; $display("FAIL fetch_done: got done %b data %h want 1 abcd", i_done, i_rdata); end
    @(posedge clk); #1;
    mem_ack = 0; mem_rdata = 16'h0; i_readM = 0;
    @(negedge clk);
    n_checks++; if (i_done !== 1'b0 || i_rdata !== 16'hABCD) begin n_errors++; $display("FAIL fetch_after: got done %b data %h want 0 abcd", i_done, i_rdata); end
    n_checks++; if (grant_cnt_i !== 16'd1 || mem_req !== 1'b0) begin n_errors++; $display("FAIL fetch_count: got cnt %0d req %b want 1 0", grant_cnt_i, mem_req); end
  endtask

  task automatic test_store();
    bit ok;
    @(posedge clk); #1;
    d_writeM = 1; d_address = 16'h0200; d_wdata = 16'h1234;
    ok = 0;
    for (int n = 0; n < 8; n++) begin @(negedge clk); if (mem_req === 1'b1) begin ok = 1; break; end end
    n_checks++; if (!ok) begin n_errors++; $display("FAIL store_grant_timeout: got no mem_req want mem_req"); end
    n_checks++; if (mem_we !== 1'b1 || mem_wdata !== 16'h1234 || mem_addr !== 16'h0200) begin n_errors++; $display("FAIL store_bus: got we %b wdata %h addr %h want 1 1234 0200", mem_we, mem_wdata, mem_addr); end
    @(posedge clk); #1;
    d_wdata = 16'hFFFF; d_address = 16'h0BAD;
    @(negedge clk);
    n_checks++; if (mem_we !== 1'b1 || mem_wdata !== 16'h1234 || mem_addr !== 16'h0200 || d_done !== 1'b0) begin n_errors++; $display("FAIL store_stable: got we %b wdata %h addr %h done %b want 1 1234 0200 0", mem_we, mem_wdata, mem_addr, d_done); end
    @(posedge clk); #1;
    mem_ack = 1; mem_rdata = 16'h5555;
    @(negedge clk);
    n_checks++; if (d_done !== 1'b1 || d_rdata !== 16'h0) begin n_errors++; $display("FAIL store_done: got done %b data %h want 1 0000", d_done, d_rdata); end
    @(posedge clk); #1;
    mem_ack = 0; d_writeM = 0;
    @(negedge clk);
    n_checks++; if (d_done !== 1'b0 || d_rdata !== 16'h0 || grant_cnt_d !== 16'd1 || mem_req !== 1'b0) begin n_errors++; $display("FAIL store_after: got done %b data %h cnt %0d req %b want 0 0000 1 0", d_done, d_rdata, grant_cnt_d, mem_req); end
  endtask

  task automatic test_simultaneous();
    bit ok;
    do_reset();
    @(posedge clk); #1;
    i_readM = 1; i_address = 16'h0040; d_readM = 1; d_address = 16'h0300;
    ok = 0;
    for (int n = 0; n < 8; n++) begin @(negedge clk); if (mem_req === 1'b1) begin ok = 1; break; end end
    n_checks++; if (!ok) begin n_errors++; $display("FAIL simul_grant_timeout: got no mem_req want mem_req"); end
    n_checks++; if (mem_addr !== 16'h0300 || mem_we !== 1'b0) begin n_errors++; $display("FAIL simul_first_d: got addr %h we %b want 0300 0", mem_addr, mem_we); end
    @(posedge clk); #1;
    mem_ack = 1; mem_rdata = 16'h1111;
    @(negedge clk);
    n_checks++; if (d_done !== 1'b1 || i_done !== 1'b0 || d_rdata !== 16'h1111 || i_wait !== 1'b1) begin n_errors++; $display("FAIL simul_d_done: got dd %b id %b data %h iw %b want 1 0 1111 1", d_done, i_done, d_rdata, i_wait); end
    @(posedge clk); #1;
    mem_ack = 0; d_readM = 0;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0040 || d_rdata !== 16'h1111) begin n_errors++; $display("FAIL simul_handoff: got req %b addr %h ddata %h want 1 0040 1111", mem_req, mem_addr, d_rdata); end
    @(posedge clk); #1;
    mem_ack = 1; mem_rdata = 16'h2222;
    @(negedge clk);
    n_checks++; if (i_done !== 1'b1 || i_rdata !== 16'h2222) begin n_errors++; $display("FAIL simul_i_done: got done %b data %h want 1 2222", i_done, i_rdata); end
    @(posedge clk); #1;
    mem_ack = 0; i_readM = 0;
    @(negedge clk);
    n_checks++; if (grant_cnt_d !== 16'd1 || grant_cnt_i !== 16'd1 || mem_req !== 1'b0) begin n_errors++; $display("FAIL simul_counts: got d %0d i %0d req %b want 1 1 0", grant_cnt_d, grant_cnt_i, mem_req); end
  endtask

  task automatic test_contention();
    int  rem_i, rem_d, ni, nd;
    bit  last_d;
    bit  exp_q[$];   // 1 = data side expected to be served
    bit  side_d;
    // expected service order: each requester has 4 accesses; ties go against the last winner
    rem_i = 4; rem_d = 4; last_d = 0;
    while (rem_i + rem_d > 0) begin
      if (rem_d > 0 && (rem_i == 0 || !last_d)) begin exp_q.push_back(1'b1); rem_d--; last_d = 1; end
      else begin exp_q.push_back(1'b0); rem_i--; last_d = 0; end
    end
    do_reset();
    @(posedge clk); #1;
    ni = 0; nd = 0;
    i_readM = 1; i_address = 16'h1000; d_readM = 1; d_address = 16'h2000;
    @(posedge clk); #1;
    mem_ack = 1; mem_rdata = 16'hC000;
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      side_d = d_done;
      n_checks++;
      if ((d_done ^ i_done) !== 1'b1 || side_d !== exp_q[j] || mem_req !== 1'b1) begin
        n_errors++; $display("FAIL contention_order[%0d]: got dd %b id %b req %b want served_d %b req 1", j, d_done, i_done, mem_req, exp_q[j]);
      end
      n_checks++;
      if (mem_addr !== (exp_q[j] ? d_address : i_address)) begin
        n_errors++; $display("FAIL contention_addr[%0d]: got %h want %h", j, mem_addr, exp_q[j] ? d_address : i_address);
      end
      @(posedge clk); #1;
      if (side_d) begin nd++; if (nd < 4) d_address = 16'h2000 + 16'(nd); else d_readM = 0; end
      else        begin ni++; if (ni < 4) i_address = 16'h1000 + 16'(ni); else i_readM = 0; end
      if (j < 7) mem_rdata = 16'hC000 + 16'(j + 1);
      else       mem_ack = 0;
    end
    @(negedge clk);
    n_checks++; if (grant_cnt_d !== 16'd4 || grant_cnt_i !== 16'd4 || mem_req !== 1'b0) begin n_errors++; $display("FAIL contention_counts: got d %0d i %0d req %b want 4 4 0", grant_cnt_d, grant_cnt_i, mem_req); end
  endtask

  task automatic test_stray_ack();
    // last contention data: I got C007, D (read) got C006
    @(posedge clk); #1;
    mem_ack = 1; mem_rdata = 16'hDEAD;
    @(negedge clk);
    n_checks++; if (i_done !== 1'b0 || d_done !== 1'b0 || i_rdata !== 16'hC007 || d_rdata !== 16'hC006) begin n_errors++; $display("FAIL stray_idle: got id %b dd %b i %h d %h want 0 0 c007 c006", i_done, d_done, i_rdata, d_rdata); end
    @(posedge clk); #1;
    n_checks++; if (mem_req !== 1'b0 || grant_cnt_i !== 16'd4) begin n_errors++; $display("FAIL stray_state: got req %b cnt_i %0d want 0 4", mem_req, grant_cnt_i); end
    i_readM = 1; i_address = 16'h0077; mem_rdata = 16'hBEEF;
    @(negedge clk);
    n_checks++; if (i_done !== 1'b0 || i_rdata !== 16'hC007 || i_wait !== 1'b1) begin n_errors++; $display("FAIL stray_pending: got done %b data %h wait %b want 0 c007 1", i_done, i_rdata, i_wait); end
    @(posedge clk); #1;
    mem_ack = 0;
    @(negedge clk);
    n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0077 || grant_cnt_i !== 16'd5 || i_rdata !== 16'hC007) begin n_errors++; $display("FAIL stray_grant: got req %b addr %h cnt %0d data %h want 1 0077 5 c007", mem_req, mem_addr, grant_cnt_i, i_rdata); end
    @(posedge clk); #1;
    mem_ack = 1; mem_rdata = 16'h7777;
    @(negedge clk);
    n_checks++; if (i_done !== 1'b1 || i_rdata !== 16'h7777) begin n_errors++; $display("FAIL stray_complete: got done %b data %h want 1 7777", i_done, i_rdata); end
    @(posedge clk); #1;
    mem_ack = 0; i_readM = 0;
  endtask

  task automatic test_reset_mid();
    bit ok;
    @(posedge clk); #1;
    d_writeM = 1; d_address = 16'h0400; d_wdata = 16'hA5A5;
    ok = 0;
    for (int n = 0; n < 8; n++) begin @(negedge clk); if (mem_req === 1'b1) begin ok = 1; break; end end
    n_checks++; if (!ok || mem_we !== 1'b1) begin n_errors++; $display("FAIL rstmid_grant: got req %b we %b want 1 1", mem_req, mem_we); end
    @(posedge clk); #3;
    reset_n = 0; d_writeM = 0;
    #1;
    n_checks++; if (mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== 16'h0 || mem_wdata !== 16'h0) begin n_errors++; $display("FAIL rstmid_bus: got req %b we %b addr %h wdata %h want 0 0 0 0", mem_req, mem_we, mem_addr, mem_wdata); end
    n_checks++; if (grant_cnt_i !== 16'h0 || grant_cnt_d !== 16'h0 || i_rdata !== 16'h0 || d_rdata !== 16'h0) begin n_errors++; $display("FAIL rstmid_regs: got ci %0d cd %0d i %h d %h want 0 0 0 0", grant_cnt_i, grant_cnt_d, i_rdata, d_rdata); end
    mem_ack = 1; mem_rdata = 16'h9999;
    @(posedge clk); #1;
    reset_n = 1;
    @(negedge clk);
    n_checks++; if (d_done !== 1'b0 || i_done !== 1'b0 || d_rdata !== 16'h0 || mem_req !== 1'b0) begin n_errors++; $display("FAIL rstmid_late_ack: got dd %b id %b d %h req %b want 0 0 0 0", d_done, i_done, d_rdata, mem_req); end
    @(posedge clk); #1;
    mem_ack = 0; i_readM = 1; i_address = 16'h0050;
    ok = 0;
    for (int n = 0; n < 8; n++) begin @(negedge clk); if (mem_req === 1'b1) begin ok = 1; break; end end
    n_checks++; if (!ok || mem_addr !== 16'h0050) begin n_errors++; $display("FAIL rstmid_fetch_grant: got req %b addr %h want 1 0050", mem_req, mem_addr); end
    @(posedge clk); #1;
    mem_ack = 1; mem_rdata = 16'h4242;
    @(negedge clk);
    n_checks++; if (i_done !== 1'b1 || i_rdata !== 16'h4242) begin n_errors++; $display("FAIL rstmid_fetch_done: got done %b data %h want 1 4242", i_done, i_rdata); end
    @(posedge clk); #1;
    mem_ack = 0; i_readM = 0;
    @(negedge clk);
    n_checks++; if (grant_cnt_i !== 16'd1 || grant_cnt_d !== 16'd0 || i_rdata !== 16'h4242) begin n_errors++; $display("FAIL rstmid_after: got ci %0d cd %0d i %h want 1 0 4242", grant_cnt_i, grant_cnt_d, i_rdata); end
  endtask

  task automatic test_random();
    for (int a = 0; a < 256; a++) begin
      ref_mem[a] = 16'(a * 16'h0101) ^ 16'h3C5A;
      sim_mem[a] = ref_mem[a];
    end
    do_reset();
    r_ni = 0; r_nd = 0;
    fork
      begin : fetch_requester
        logic [15:0] last_i;
        bit got;
        int guard;
        last_i = 0; guard = 0;
        while (r_ni < N_RAND && guard < 4000) begin
          @(negedge clk); guard++;
          got = 0;
          if (i_readM && i_done) begin
            n_checks++;
            if (i_rdata !== ref_mem[i_address[7:0]]) begin n_errors++; $display("FAIL rand_fetch_data: got %h want %h addr %h", i_rdata, ref_mem[i_address[7:0]], i_address); end
            last_i = ref_mem[i_address[7:0]];
            got = 1;
          end else begin
            n_checks++;
            if (i_rdata !== last_i) begin n_errors++; $display("FAIL rand_fetch_hold: got %h want %h", i_rdata, last_i); end
          end
          @(posedge clk); #1;
          if (got) begin
            r_ni++;
            i_readM = 0;
            if (r_ni < N_RAND && $urandom_range(0, 3) != 0) begin i_readM = 1; i_address = 16'($urandom); end
          end else if (!i_readM && $urandom_range(0, 1) == 1) begin
            i_readM = 1; i_address = 16'($urandom);
          end
        end
        i_readM = 0;
      end
      begin : data_requester
        logic [15:0] last_d;
        bit got;
        int guard;
        int kind;
        last_d = 0; guard = 0;
        while (r_nd < N_RAND && guard < 4000) begin
          @(negedge clk); guard++;
          got = 0;
          if ((d_readM || d_writeM) && d_done) begin
            n_checks++;
            if (i_done !== 1'b0) begin n_errors++; $display("FAIL rand_double_done: got i_done %b want 0", i_done); end
            n_checks++;
            if (d_writeM) begin
              if (d_rdata !== last_d) begin n_errors++; $display("FAIL rand_store_rdata: got %h want %h", d_rdata, last_d); end
              ref_mem[d_address[7:0]] = d_wdata;
            end else begin
              if (d_rdata !== ref_mem[d_address[7:0]]) begin n_errors++; $display("FAIL rand_load_data: got %h want %h addr %h", d_rdata, ref_mem[d_address[7:0]], d_address); end
              last_d = ref_mem[d_address[7:0]];
            end
            got = 1;
          end else begin
            n_checks++;
            if (d_rdata !== last_d) begin n_errors++; $display("FAIL rand_load_hold: got %h want %h", d_rdata, last_d); end
          end
          @(posedge clk); #1;
          if (got || (!d_readM && !d_writeM)) begin
            if (got) r_nd++;
            d_readM = 0; d_writeM = 0;
            if (r_nd < N_RAND && $urandom_range(0, 3) != 0) begin
              kind = int'($urandom_range(0, 3));
              d_readM   = (kind != 2);
              d_writeM  = (kind >= 2);
              d_address = 16'($urandom);
              d_wdata   = 16'($urandom);
            end
          end
        end
        d_readM = 0; d_writeM = 0;
      end
      begin : memory_responder
        int lat;
        int cyc;
        lat = 0; cyc = 0;
        while ((r_ni < N_RAND || r_nd < N_RAND) && cyc < 4000) begin
          @(posedge clk); #1; cyc++;
          if (mem_ack) begin
            mem_ack = 0;
            mem_rdata = 16'($urandom);
            lat = int'($urandom_range(0, 2));
          end else if (mem_req) begin
            if (lat == 0) begin
              mem_ack = 1;
              mem_rdata = sim_mem[mem_addr[7:0]];
              if (mem_we) sim_mem[mem_addr[7:0]] = mem_wdata;
            end else begin
              lat--;
              mem_rdata = 16'($urandom);
            end
          end else begin
            mem_rdata = 16'($urandom);
          end
        end
      end
    join
    mem_ack = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++; if (r_ni != N_RAND || r_nd != N_RAND) begin n_errors++; $display("FAIL rand_timeout: got fetches %0d data %0d want %0d each", r_ni, r_nd, N_RAND); end
    n_checks++; if (grant_cnt_i !== 16'(N_RAND) || grant_cnt_d !== 16'(N_RAND) || mem_req !== 1'b0) begin n_errors++; $display("FAIL rand_counts: got ci %0d cd %0d req %b want %0d %0d 0", grant_cnt_i, grant_cnt_d, mem_req, N_RAND, N_RAND); end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_simultaneous();
    test_contention();
    test_stray_ack();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
